oam_dma_controller: RTL and testbench

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

---
 rtl/oam_dma_controller.sv | 97 +++++++++
 tb/tb_oam_dma_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// OAM sprite DMA: halts the CPU and copies one 256-byte page to OAMDATA as read/write pairs.
// 513 active cycles (514 if HALT lands odd); ENABLE=0 freezes all state; DONE pulses once per transfer.
module oam_dma_controller #(
   parameter logic [15:0] OAM_DMA_REG  = 16'h4014,
   parameter logic [15:0] OAM_DATA_REG = 16'h2004
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DATA_OUT,
   input  logic        CPU_RW_n,
   input  logic [7:0]  BUS_DATA_IN,
   output logic        CPU_HALT,
   output logic        DMA_ACTIVE,
   output logic [15:0] DMA_ADDR,
   output logic [7:0]  DMA_DATA_OUT,
   output logic        DMA_RW_n,
   output logic        DONE
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_FINISH
   } state_t;

   state_t      state_q;
   logic        parity_q;
   logic [7:0]  page_q;
   logic [7:0]  idx_q;
   logic [7:0]  data_q;
   logic        trigger;

   assign trigger = !CPU_RW_n && (CPU_ADDR == OAM_DMA_REG);

   // Outputs are registered alongside the state they belong to, so each transition sets them for the next cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         parity_q     <= 1'b0;
         page_q       <= 8'h00;
         idx_q        <= 8'h00;
         data_q       <= 8'h00;
         CPU_HALT     <= 1'b0;
         DMA_ACTIVE   <= 1'b0;
         DMA_ADDR     <= 16'h0000;
         DMA_DATA_OUT <= 8'h00;
         DMA_RW_n     <= 1'b1;
         DONE         <= 1'b0;
      end else if (ENABLE) begin
         parity_q <= ~parity_q;
         DONE     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (trigger) begin
                  page_q     <= CPU_DATA_OUT;
                  idx_q      <= 8'h00;
                  state_q    <= S_HALT;
                  CPU_HALT   <= 1'b1;
                  DMA_ACTIVE <= 1'b1;
                  DMA_ADDR   <= {CPU_DATA_OUT, 8'h00};
                  DMA_RW_n   <= 1'b1;
               end
            end
            // Dummy read address {page,00} equals the first real read address, so it simply carries over.
            S_HALT:  state_q <= parity_q ? S_ALIGN : S_READ;
            S_ALIGN: state_q <= S_READ;
            S_READ: begin
               data_q       <= BUS_DATA_IN;
               DMA_DATA_OUT <= BUS_DATA_IN;
               DMA_ADDR     <= OAM_DATA_REG;
               DMA_RW_n     <= 1'b0;
               state_q      <= S_WRITE;
            end
            S_WRITE: begin
               if (idx_q == 8'hFF) begin
                  state_q      <= S_FINISH;
                  CPU_HALT     <= 1'b0;
                  DMA_ACTIVE   <= 1'b0;
                  DMA_ADDR     <= 16'h0000;
                  DMA_DATA_OUT <= 8'h00;
                  DMA_RW_n     <= 1'b1;
                  DONE         <= 1'b1;
               end else begin
                  idx_q        <= idx_q + 8'd1;
                  DMA_ADDR     <= {page_q, idx_q + 8'd1};
                  DMA_DATA_OUT <= data_q;
                  DMA_RW_n     <= 1'b1;
                  state_q      <= S_READ;
               end
            end
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: memory model on the bus, scoreboard of expected read addresses / write data.
`timescale 1ns/1ps
module tb_oam_dma_controller;

   logic        CLK;
   logic        RESET;
   logic        ENABLE;
   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DATA_OUT;
   logic        CPU_RW_n;
   logic [7:0]  BUS_DATA_IN;
   logic        CPU_HALT;
   logic        DMA_ACTIVE;
   logic [15:0] DMA_ADDR;
   logic [7:0]  DMA_DATA_OUT;
   logic        DMA_RW_n;
   logic        DONE;

   oam_dma_controller dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
      .CPU_ADDR(CPU_ADDR), .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_RW_n(CPU_RW_n),
      .BUS_DATA_IN(BUS_DATA_IN),
      .CPU_HALT(CPU_HALT), .DMA_ACTIVE(DMA_ACTIVE), .DMA_ADDR(DMA_ADDR),
      .DMA_DATA_OUT(DMA_DATA_OUT), .DMA_RW_n(DMA_RW_n), .DONE(DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // System RAM contents: page 2 holds i^5A; other pages are offset so a wrong page shows up in the data.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
   endfunction

   assign BUS_DATA_IN = (DMA_ACTIVE && DMA_RW_n) ? mem_byte(DMA_ADDR) : 8'hEE;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];
   int          act_cnt = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   bit          zero_seen = 0;
   logic [15:0] prev_addr = 16'h0000;
   logic        prev_rw = 1'b1;
   logic        tb_par;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Parity of enabled cycles since reset, used only to place the trigger.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) tb_par <= 1'b0;
      else if (ENABLE) tb_par <= ~tb_par;
   end

   always @(negedge CLK) begin
      if (!RESET && ENABLE) begin
         if (DONE) begin
            done_cnt++;
            check("done_while_active", {31'b0, DMA_ACTIVE}, 0);
         end
         if (DMA_ACTIVE) begin : act_blk
            logic [15:0] ea;
            logic [7:0]  ed;
            act_cnt++;
            if (DMA_ADDR == 16'h0000) zero_seen = 1;
            if (!DMA_RW_n) begin
               wr_cnt++;
               check("wr_addr_halt", {DMA_ADDR, 15'b0, CPU_HALT}, {16'h2004, 15'b0, 1'b1});
               if (exp_data_q.size() == 0) begin
                  check("scoreboard_empty", 1, 0);
               end else begin
                  ea = exp_addr_q.pop_front();
                  ed = exp_data_q.pop_front();
                  check("rd_addr", {15'b0, prev_rw, prev_addr}, {15'b0, 1'b1, ea});
                  check("wr_data", {24'b0, DMA_DATA_OUT}, {24'b0, ed});
               end
            end
            prev_addr = DMA_ADDR;
            prev_rw   = DMA_RW_n;
         end else begin
            check("idle_outputs", {6'b0, CPU_HALT, DMA_ADDR, DMA_DATA_OUT, DMA_RW_n},
                  {6'b0, 1'b0, 16'h0000, 8'h00, 1'b1});
         end
      end
   end

   task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
      CPU_ADDR = a; CPU_DATA_OUT = d; CPU_RW_n = rw;
      @(posedge CLK); #1;
      CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {5'b0, CPU_HALT, DMA_ACTIVE, DMA_ADDR, DMA_DATA_OUT, DMA_RW_n, DONE},
            {5'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0});
   endtask

   task automatic run_xfer(input logic [7:0] page, input bit halt_odd, input bit stall, input bit fin_trig);
      logic [18:0] held;
      bit          got;
      got = 0;
      for (int k = 0; k < 4 && ((~tb_par) != halt_odd); k++) begin
         @(posedge CLK); #1;
      end
      act_cnt = 0; wr_cnt = 0; done_cnt = 0; zero_seen = 0;
      for (int i = 0; i < 256; i++) begin
         exp_addr_q.push_back({page, 8'(i)});
         exp_data_q.push_back(mem_byte({page, 8'(i)}));
      end
      cpu_cycle(16'h4014, page, 1'b0);
      check("halt_dummy_rd", {13'b0, CPU_HALT, DMA_ACTIVE, DMA_RW_n, DMA_ADDR}, {13'b0, 3'b111, page, 8'h00});
      for (int c = 0; c < 2000 && !got; c++) begin
         CPU_RW_n = (c == 20) ? 1'b0 : 1'b1;
         CPU_ADDR = (c == 20) ? 16'h4014 : 16'h0000;
         CPU_DATA_OUT = 8'h07;
         if (stall && c == 60) begin
            held = {CPU_HALT, DMA_ACTIVE, DMA_RW_n, DMA_ADDR};
            ENABLE = 1'b0;
            repeat (5) @(posedge CLK);
            #1;
            check("stall_hold", {13'b0, CPU_HALT, DMA_ACTIVE, DMA_RW_n, DMA_ADDR}, {13'b0, held});
            ENABLE = 1'b1;
         end
         @(posedge CLK); #1;
         got = DONE;
      end
      CPU_RW_n = 1'b1; CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00;
      check("done_seen", {31'b0, got}, 1);
      if (fin_trig) cpu_cycle(16'h4014, 8'h11, 1'b0);
      repeat (2) begin @(posedge CLK); #1; end
      check("idle_after_done", {30'b0, CPU_HALT, DMA_ACTIVE}, 0);
      check("active_cycles", act_cnt, halt_odd ? 514 : 513);
      check("write_count", wr_cnt, 256);
      check("done_count", done_cnt, 1);
      check("scoreboard_left", exp_data_q.size(), 0);
      check("zero_addr_seen", {31'b0, zero_seen}, 0);
      exp_addr_q.delete(); exp_data_q.delete();
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        rw_n;
      logic        en;
      logic        exp_halt;
   } vec_t;

   initial begin
      vec_t vecs[6];
      vecs[0] = '{16'h4014, 8'h02, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{16'h4015, 8'h02, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{16'h2014, 8'h02, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'h0014, 8'h02, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'h4014, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'hC014, 8'h02, 1'b0, 1'b1, 1'b0};

      RESET = 1'b1; ENABLE = 1'b1;
      CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
      #1;
      check_reset_outputs("reset_t0");
      repeat (2) @(posedge CLK);
      #1;
      check_reset_outputs("reset_clocked");
      RESET = 1'b0;
      repeat (2) begin @(posedge CLK); #1; end

      for (int v = 0; v < 6; v++) begin
         ENABLE = vecs[v].en;
         cpu_cycle(vecs[v].addr, vecs[v].data, vecs[v].rw_n);
         ENABLE = 1'b1;
         check($sformatf("no_trigger_%0d", v), {30'b0, CPU_HALT, DMA_ACTIVE}, {30'b0, vecs[v].exp_halt, vecs[v].exp_halt});
         @(posedge CLK); #1;
         check($sformatf("no_trigger_late_%0d", v), {30'b0, CPU_HALT, DMA_ACTIVE}, {30'b0, vecs[v].exp_halt, vecs[v].exp_halt});
      end

      run_xfer(8'h02, 1'b0, 1'b0, 1'b0);
      run_xfer(8'h02, 1'b1, 1'b1, 1'b1);
      run_xfer(8'hFF, 1'b0, 1'b0, 1'b0);

      // Abort a transfer with reset after its 100th write.
      for (int i = 0; i < 256; i++) begin
         exp_addr_q.push_back({8'h02, 8'(i)});
         exp_data_q.push_back(mem_byte({8'h02, 8'(i)}));
      end
      wr_cnt = 0; done_cnt = 0;
      cpu_cycle(16'h4014, 8'h02, 1'b0);
      for (int c = 0; c < 1500 && wr_cnt < 100; c++) begin
         @(posedge CLK); #1;
      end
      check("reached_100_writes", {31'b0, wr_cnt >= 100}, 1);
      #2 RESET = 1'b1;
      #1;
      check_reset_outputs("reset_async_mid");
      exp_addr_q.delete(); exp_data_q.delete();
      @(posedge CLK); #1;
      check_reset_outputs("reset_held_mid");
      RESET = 1'b0;
      repeat (3) begin @(posedge CLK); #1; end
      check("no_done_after_abort", done_cnt, 0);
      run_xfer(8'h03, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
